pic_isr_ctrl: RTL and testbench



---
 rtl/pic_pkg.sv | 20 ++
 rtl/pic_prio_resolver.sv | 50 +++++
 rtl/pic_isr_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_pic_isr_ctrl.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pic_pkg.sv
// Shared definitions for the PIC in-service controller: acknowledge FSM
// states, default channel count and the spurious vector index.
package pic_pkg;

    // Acknowledge sequence: IDLE waits for the first INTA pulse, ACK1 for the second.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        ACK1 = 1'b1
    } pic_state_t;

    localparam int PIC_N_IRQ_DEFAULT = 8;

    // A spurious acknowledge reports the last channel index.
    localparam int PIC_SPURIOUS_IDX_DEFAULT = PIC_N_IRQ_DEFAULT - 1;

    function automatic int pic_spurious_idx(input int n_irq);
        return n_irq - 1;
    endfunction

endpackage

// File: rtl/pic_prio_resolver.sv
// Combinational rotated priority encoder. The channel just above i_lowest
// has rank 0 (highest); ranks wrap modulo N_IRQ. Reports the highest-ranked
// set bit of i_vec, its channel index and its rank.
module pic_prio_resolver
    import pic_pkg::*;
#(
    parameter  int N_IRQ = PIC_N_IRQ_DEFAULT,
    localparam int IDX_W = $clog2(N_IRQ)
) (
    input  logic [N_IRQ-1:0] i_vec,
    input  logic [IDX_W-1:0] i_lowest,
    output logic             o_valid,
    output logic [IDX_W-1:0] o_idx,
    output logic [IDX_W-1:0] o_rank
);

    localparam int SUM_W = IDX_W + 1;

    // w_rank_ch[r] is the channel that currently holds rank r
    logic [IDX_W-1:0] w_rank_ch [N_IRQ];
    logic [N_IRQ-1:0] w_by_rank;

    genvar gi;
    generate
        for (gi = 0; gi < N_IRQ; gi++) begin : g_rank
            logic [SUM_W-1:0] w_sum;
            // lowest + 1 + r never exceeds 2*N_IRQ-1, so one conditional
            // subtraction is a full modulo, also for non-power-of-2 N_IRQ
            assign w_sum = {1'b0, i_lowest} + SUM_W'(gi + 1);
            assign w_rank_ch[gi] = (w_sum >= SUM_W'(N_IRQ)) ? IDX_W'(w_sum - SUM_W'(N_IRQ))
                                                            : IDX_W'(w_sum);
            assign w_by_rank[gi] = i_vec[w_rank_ch[gi]];
        end
    endgenerate

    // Pick the lowest rank number with a request; later iterations win
    always_comb begin
        o_valid = 1'b0;
        o_idx   = '0;
        o_rank  = '0;
        for (int r = N_IRQ - 1; r >= 0; r--) begin
            if (w_by_rank[r]) begin
                o_valid = 1'b1;
                o_idx   = w_rank_ch[r];
                o_rank  = IDX_W'(r);
            end
        end
    end

endmodule

// File: rtl/pic_isr_ctrl.sv
// PIC in-service controller: resolves the pending request under a rotating
// priority order, drives INT, runs the two-pulse INTA acknowledge, and
// retires in-service bits through specific, non-specific or automatic EOI.
module pic_isr_ctrl
    import pic_pkg::*;
#(
    parameter  int N_IRQ = PIC_N_IRQ_DEFAULT,
    localparam int IDX_W = $clog2(N_IRQ)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_IRQ-1:0] interrupt_request,
    input  logic [N_IRQ-1:0] interrupt_mask,
    input  logic             inta,
    input  logic             aeoi_mode,
    input  logic             rotate_aeoi,
    input  logic             eoi_ns,
    input  logic             eoi_sp,
    input  logic             eoi_rotate,
    input  logic             set_prio,
    input  logic [IDX_W-1:0] eoi_idx,
    output logic             int_req,
    output logic [N_IRQ-1:0] in_service_register,
    output logic [N_IRQ-1:0] irr_clear,
    output logic             vector_valid,
    output logic [IDX_W-1:0] vector_idx,
    output logic [IDX_W-1:0] lowest_prio
);

    localparam logic [IDX_W-1:0] SPUR_IDX     = IDX_W'(pic_spurious_idx(N_IRQ));
    localparam logic [IDX_W-1:0] RESET_LOWEST = IDX_W'(N_IRQ - 1);

    pic_state_t       r_state;
    pic_state_t       w_state_next;
    logic [N_IRQ-1:0] r_isr;
    logic [N_IRQ-1:0] r_irr_clear;
    logic [IDX_W-1:0] r_lowest;
    logic [IDX_W-1:0] r_ack_idx;
    logic [IDX_W-1:0] r_vector_idx;
    logic             r_ack_spurious;
    logic             r_int_req;
    logic             r_vector_valid;

    logic             w_cand_valid;
    logic [IDX_W-1:0] w_cand_idx;
    logic [IDX_W-1:0] w_cand_rank;
    logic             w_top_valid;
    logic [IDX_W-1:0] w_top_idx;
    logic [IDX_W-1:0] w_top_rank;

    logic             w_ack_first;
    logic             w_ack_second;
    logic [N_IRQ-1:0] w_sp_onehot;
    logic [N_IRQ-1:0] w_cand_onehot;
    logic [N_IRQ-1:0] w_top_onehot;
    logic [N_IRQ-1:0] w_ack_onehot;
    logic [N_IRQ-1:0] w_ack_set;
    logic [N_IRQ-1:0] w_cmd_clear;
    logic             w_cmd_rot;
    logic [IDX_W-1:0] w_cmd_rot_idx;
    logic             w_aeoi_fire;
    logic [N_IRQ-1:0] w_aeoi_clear;
    logic [N_IRQ-1:0] w_isr_next;
    logic [IDX_W-1:0] w_lowest_next;
    logic             w_int_req_next;

    // Highest-priority unmasked request
    pic_prio_resolver #(.N_IRQ(N_IRQ)) u_cand_resolver (
        .i_vec    (interrupt_request & ~interrupt_mask),
        .i_lowest (r_lowest),
        .o_valid  (w_cand_valid),
        .o_idx    (w_cand_idx),
        .o_rank   (w_cand_rank)
    );

    // Highest-priority channel currently in service
    pic_prio_resolver #(.N_IRQ(N_IRQ)) u_isr_resolver (
        .i_vec    (r_isr),
        .i_lowest (r_lowest),
        .o_valid  (w_top_valid),
        .o_idx    (w_top_idx),
        .o_rank   (w_top_rank)
    );

    // Index decoders; an out-of-range eoi_idx decodes to all zeros and is ignored
    genvar gi;
    generate
        for (gi = 0; gi < N_IRQ; gi++) begin : g_dec
            assign w_sp_onehot[gi]   = (eoi_idx == IDX_W'(gi));
            assign w_cand_onehot[gi] = w_cand_valid && (w_cand_idx == IDX_W'(gi));
            assign w_top_onehot[gi]  = w_top_valid && (w_top_idx == IDX_W'(gi));
            assign w_ack_onehot[gi]  = (r_ack_idx == IDX_W'(gi));
        end
    endgenerate

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state: each INTA pulse advances the two-step acknowledge
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (inta) w_state_next = ACK1;
            ACK1:    if (inta) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // FSM outputs: which INTA pulse is being taken this cycle
    always_comb begin
        w_ack_first  = 1'b0;
        w_ack_second = 1'b0;
        case (r_state)
            IDLE:    w_ack_first  = inta;
            ACK1:    w_ack_second = inta;
            default: ;
        endcase
    end

    // EOI / priority command decode; only the highest-precedence strobe acts
    always_comb begin
        w_cmd_clear   = '0;
        w_cmd_rot     = 1'b0;
        w_cmd_rot_idx = r_lowest;
        if (eoi_sp) begin
            w_cmd_clear = w_sp_onehot & r_isr;
            if (eoi_rotate && (|(w_sp_onehot & r_isr))) begin
                w_cmd_rot     = 1'b1;
                w_cmd_rot_idx = eoi_idx;
            end
        end else if (eoi_ns) begin
            w_cmd_clear = w_top_onehot;
            if (eoi_rotate && w_top_valid) begin
                w_cmd_rot     = 1'b1;
                w_cmd_rot_idx = w_top_idx;
            end
        end else if (set_prio) begin
            if (|w_sp_onehot) begin
                w_cmd_rot     = 1'b1;
                w_cmd_rot_idx = eoi_idx;
            end
        end
    end

    // Next ISR, priority and INT: clears use pre-edge ISR, a same-edge set wins,
    // and command rotation takes precedence over automatic-EOI rotation
    always_comb begin
        w_ack_set      = w_ack_first ? w_cand_onehot : '0;
        w_aeoi_fire    = w_ack_second && aeoi_mode && !r_ack_spurious;
        w_aeoi_clear   = w_aeoi_fire ? w_ack_onehot : '0;
        w_isr_next     = (r_isr & ~(w_cmd_clear | w_aeoi_clear)) | w_ack_set;
        w_lowest_next  = r_lowest;
        if (w_cmd_rot) begin
            w_lowest_next = w_cmd_rot_idx;
        end else if (w_aeoi_fire && rotate_aeoi) begin
            w_lowest_next = r_ack_idx;
        end
        w_int_req_next = w_cand_valid && (!w_top_valid || (w_cand_rank < w_top_rank))
                         && (w_state_next == IDLE);
    end

    // Registered datapath and outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_isr          <= '0;
            r_irr_clear    <= '0;
            r_lowest       <= RESET_LOWEST;
            r_ack_idx      <= '0;
            r_ack_spurious <= 1'b0;
            r_vector_idx   <= '0;
            r_vector_valid <= 1'b0;
            r_int_req      <= 1'b0;
        end else begin
            r_isr          <= w_isr_next;
            r_irr_clear    <= w_ack_set;
            r_lowest       <= w_lowest_next;
            r_int_req      <= w_int_req_next;
            r_vector_valid <= w_ack_second;
            if (w_ack_second) begin
                r_vector_idx <= r_ack_idx;
            end
            if (w_ack_first) begin
                r_ack_idx      <= w_cand_valid ? w_cand_idx : SPUR_IDX;
                r_ack_spurious <= !w_cand_valid;
            end
        end
    end

    assign int_req             = r_int_req;
    assign in_service_register = r_isr;
    assign irr_clear           = r_irr_clear;
    assign vector_valid        = r_vector_valid;
    assign vector_idx          = r_vector_idx;
    assign lowest_prio         = r_lowest;

endmodule

// File: tb/tb_pic_isr_ctrl.sv
// Bench for pic_isr_ctrl: directed vector table (8 channels), a hand
// sequence on a 5-channel build, and randomized traffic against a model.
module tb_pic_isr_ctrl;

    localparam int N = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 8-channel instance
    logic       reset;
    logic [7:0] irr, imr;
    logic       inta, aeoi_mode, rotate_aeoi, eoi_ns, eoi_sp, eoi_rotate, set_prio;
    logic [2:0] eoi_idx;
    logic       int_req, vector_valid;
    logic [7:0] isr, irr_clear;
    logic [2:0] vector_idx, lowest_prio;

    pic_isr_ctrl #(.N_IRQ(8)) u_dut (
        .clk(clk), .reset(reset),
        .interrupt_request(irr), .interrupt_mask(imr),
        .inta(inta), .aeoi_mode(aeoi_mode), .rotate_aeoi(rotate_aeoi),
        .eoi_ns(eoi_ns), .eoi_sp(eoi_sp), .eoi_rotate(eoi_rotate),
        .set_prio(set_prio), .eoi_idx(eoi_idx),
        .int_req(int_req), .in_service_register(isr), .irr_clear(irr_clear),
        .vector_valid(vector_valid), .vector_idx(vector_idx), .lowest_prio(lowest_prio)
    );

    // 5-channel instance
    logic       reset5, inta5, set_prio5;
    logic [4:0] irr5;
    logic [2:0] eoi_idx5;
    logic       int_req5, vv5;
    logic [4:0] isr5, clr5;
    logic [2:0] vidx5, low5;

    pic_isr_ctrl #(.N_IRQ(5)) u_dut5 (
        .clk(clk), .reset(reset5),
        .interrupt_request(irr5), .interrupt_mask(5'b0),
        .inta(inta5), .aeoi_mode(1'b0), .rotate_aeoi(1'b0),
        .eoi_ns(1'b0), .eoi_sp(1'b0), .eoi_rotate(1'b0),
        .set_prio(set_prio5), .eoi_idx(eoi_idx5),
        .int_req(int_req5), .in_service_register(isr5), .irr_clear(clr5),
        .vector_valid(vv5), .vector_idx(vidx5), .lowest_prio(low5)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic       rst;
        logic [7:0] irr, imr;
        logic       inta, aeoi, rota, ns, sp, erot, sprio;
        logic [2:0] idx;
        logic       e_int;
        logic [7:0] e_isr, e_clr;
        logic       e_vv;
        logic [2:0] e_vidx, e_low;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic rst, input logic [7:0] ir, input logic [7:0] im,
                       input logic ia, input logic ae, input logic ra, input logic ns,
                       input logic sp, input logic er, input logic spr, input logic [2:0] ix,
                       input logic ei, input logic [7:0] es, input logic [7:0] ec,
                       input logic ev, input logic [2:0] evi, input logic [2:0] el);
        vec_t v;
        v.rst = rst; v.irr = ir; v.imr = im; v.inta = ia; v.aeoi = ae; v.rota = ra;
        v.ns = ns; v.sp = sp; v.erot = er; v.sprio = spr; v.idx = ix;
        v.e_int = ei; v.e_isr = es; v.e_clr = ec; v.e_vv = ev; v.e_vidx = evi; v.e_low = el;
        tbl.push_back(v);
    endtask

    // ---------------- reference model ----------------
    logic       m_ack, m_spur, m_int, m_vv;
    int         m_idx, m_low, m_vidx;
    logic [7:0] m_isr, m_clr;

    function automatic int rank_of(input int ch, input int low);
        return (ch - low - 1 + 2 * N) % N;
    endfunction

    function automatic int best_of(input logic [7:0] v, input int low);
        int b = -1;
        for (int i = 0; i < N; i++)
            if (v[i] && (b < 0 || rank_of(i, low) < rank_of(b, low))) b = i;
        return b;
    endfunction

    task automatic model_step();
        int cand, top, rot_cmd, rot_ae;
        logic [7:0] clr, setm;
        logic nack;
        if (reset) begin
            m_ack = 0; m_spur = 0; m_idx = 0; m_isr = 0; m_low = N - 1;
            m_int = 0; m_clr = 0; m_vv = 0; m_vidx = 0;
            return;
        end
        cand = best_of(irr & ~imr, m_low);
        top  = best_of(m_isr, m_low);
        clr = 0; setm = 0; rot_cmd = -1; rot_ae = -1; nack = m_ack; m_vv = 0;
        if (eoi_sp) begin
            if (m_isr[eoi_idx]) begin
                clr[eoi_idx] = 1'b1;
                if (eoi_rotate) rot_cmd = int'(eoi_idx);
            end
        end else if (eoi_ns) begin
            if (top >= 0) begin
                clr[top] = 1'b1;
                if (eoi_rotate) rot_cmd = top;
            end
        end else if (set_prio) begin
            rot_cmd = int'(eoi_idx);
        end
        if (inta && !m_ack) begin
            nack = 1;
            if (cand >= 0) begin setm[cand] = 1'b1; m_idx = cand; m_spur = 0; end
            else begin m_idx = N - 1; m_spur = 1; end
        end else if (inta && m_ack) begin
            nack = 0; m_vv = 1; m_vidx = m_idx;
            if (aeoi_mode && !m_spur) begin
                clr[m_idx] = 1'b1;
                if (rotate_aeoi) rot_ae = m_idx;
            end
        end
        m_int = (cand >= 0) && (top < 0 || rank_of(cand, m_low) < rank_of(top, m_low)) && !nack;
        m_clr = setm;
        m_isr = (m_isr & ~clr) | setm;
        if (rot_cmd >= 0) m_low = rot_cmd;
        else if (rot_ae >= 0) m_low = rot_ae;
        m_ack = nack;
    endtask

    task automatic idle_inputs();
        reset = 0; irr = 0; imr = 0; inta = 0; aeoi_mode = 0; rotate_aeoi = 0;
        eoi_ns = 0; eoi_sp = 0; eoi_rotate = 0; set_prio = 0; eoi_idx = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        idle_inputs();
        reset = 1;
        reset5 = 1; inta5 = 0; set_prio5 = 0; irr5 = 0; eoi_idx5 = 0;

        //   rst irr    imr  ia ae ra ns sp er sp idx  int isr    clr   vv vidx low
        add(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0,   0, 8'h00, 8'h00, 0, 0, 7);
        add(0, 8'h24, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0,   1, 8'h00, 8'h00, 0, 0, 7);
        add(0, 8'h24, 8'h00, 1, 0, 0, 0, 0, 0, 0, 0,   0, 8'h04, 8'h04, 0, 0, 7);
        add(0, 8'h20, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0,   0, 8'h04, 8'h00, 0, 0, 7);
        add(0, 8'h20, 8'h00, 1, 0, 0, 0, 0, 0, 0, 0,   0, 8'h04, 8'h00, 1, 2, 7);
        add(0, 8'h20, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0,   0, 8'h04, 8'h00, 0, 2, 7);
        add(0, 8'h22, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0,   1, 8'h04, 8'h00, 0, 2, 7);
        add(0, 8'h22, 8'h00, 1, 0, 0, 0, 0, 0, 0, 0,   0, 8'h06, 8'h02, 0, 2, 7);
        add(0, 8'h20, 8'h00, 1, 0, 0, 0, 0, 0, 0, 0,   0, 8'h06, 8'h00, 1, 1, 7);
        add(0, 8'h20, 8'h00, 0, 0, 0, 1, 0, 0, 0, 0,   0, 8'h04, 8'h00, 0, 1, 7);
        add(0, 8'h00, 8'h00, 0, 0, 0, 0, 1, 1, 0, 2,   0, 8'h00, 8'h00, 0, 1, 2);
        add(0, 8'h09, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0,   1, 8'h00, 8'h00, 0, 1, 2);
        add(0, 8'h09, 8'h00, 1, 0, 0, 0, 0, 0, 0, 0,   0, 8'h08, 8'h08, 0, 1, 2);
        add(0, 8'h01, 8'h00, 1, 0, 0, 0, 0, 0, 0, 0,   0, 8'h08, 8'h00, 1, 3, 2);
        add(0, 8'h00, 8'h00, 0, 0, 0, 1, 0, 0, 0, 0,   0, 8'h00, 8'h00, 0, 3, 2);
        add(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 1, 7,   0, 8'h00, 8'h00, 0, 3, 7);
        add(0, 8'h80, 8'h00, 0, 1, 1, 0, 0, 0, 0, 0,   1, 8'h00, 8'h00, 0, 3, 7);
        add(0, 8'h80, 8'h00, 1, 1, 1, 0, 0, 0, 0, 0,   0, 8'h80, 8'h80, 0, 3, 7);
        add(0, 8'h00, 8'h00, 1, 1, 1, 0, 0, 0, 0, 0,   0, 8'h00, 8'h00, 1, 7, 7);
        add(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0,   0, 8'h00, 8'h00, 0, 7, 7);
        add(0, 8'h10, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0,   1, 8'h00, 8'h00, 0, 7, 7);
        add(0, 8'h00, 8'h00, 1, 0, 0, 0, 0, 0, 0, 0,   0, 8'h00, 8'h00, 0, 7, 7);
        add(0, 8'h00, 8'h00, 1, 0, 0, 0, 0, 0, 0, 0,   0, 8'h00, 8'h00, 1, 7, 7);
        add(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0,   0, 8'h00, 8'h00, 0, 7, 7);
        add(0, 8'h01, 8'h01, 0, 0, 0, 0, 0, 0, 0, 0,   0, 8'h00, 8'h00, 0, 7, 7);
        add(0, 8'h03, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0,   1, 8'h00, 8'h00, 0, 7, 7);
        add(0, 8'h03, 8'h00, 1, 0, 0, 0, 0, 0, 0, 0,   0, 8'h01, 8'h01, 0, 7, 7);
        add(0, 8'h02, 8'h00, 1, 0, 0, 0, 0, 0, 0, 0,   0, 8'h01, 8'h00, 1, 0, 7);
        add(0, 8'h02, 8'h00, 1, 0, 0, 0, 0, 0, 0, 0,   0, 8'h03, 8'h02, 0, 0, 7);
        add(0, 8'h00, 8'h00, 1, 0, 0, 0, 0, 0, 0, 0,   0, 8'h03, 8'h00, 1, 1, 7);
        add(0, 8'h00, 8'h00, 0, 0, 0, 1, 1, 1, 1, 1,   0, 8'h01, 8'h00, 0, 1, 1);
        add(0, 8'h00, 8'h00, 0, 0, 0, 1, 0, 0, 1, 4,   0, 8'h00, 8'h00, 0, 1, 1);
        add(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 1, 7,   0, 8'h00, 8'h00, 0, 1, 7);
        add(0, 8'h00, 8'h00, 0, 0, 0, 0, 1, 1, 0, 3,   0, 8'h00, 8'h00, 0, 1, 7);

        foreach (tbl[k]) begin
            reset = tbl[k].rst; irr = tbl[k].irr; imr = tbl[k].imr; inta = tbl[k].inta;
            aeoi_mode = tbl[k].aeoi; rotate_aeoi = tbl[k].rota; eoi_ns = tbl[k].ns;
            eoi_sp = tbl[k].sp; eoi_rotate = tbl[k].erot; set_prio = tbl[k].sprio;
            eoi_idx = tbl[k].idx;
            tick();
            check($sformatf("row%0d int_req", k), 32'(int_req), 32'(tbl[k].e_int));
            check($sformatf("row%0d isr", k), 32'(isr), 32'(tbl[k].e_isr));
            check($sformatf("row%0d irr_clear", k), 32'(irr_clear), 32'(tbl[k].e_clr));
            check($sformatf("row%0d vector_valid", k), 32'(vector_valid), 32'(tbl[k].e_vv));
            check($sformatf("row%0d vector_idx", k), 32'(vector_idx), 32'(tbl[k].e_vidx));
            check($sformatf("row%0d lowest_prio", k), 32'(lowest_prio), 32'(tbl[k].e_low));
            $display("[TB] row %0d irr=%02h inta=%0b -> int=%0b isr=%02h clr=%02h vv=%0b vidx=%0d low=%0d",
                     k, irr, inta, int_req, isr, irr_clear, vector_valid, vector_idx, lowest_prio);
        end
        idle_inputs();

        // ---------------- 5-channel sequence ----------------
        reset5 = 1; tick();
        check("n5 reset lowest", 32'(low5), 32'd4);
        check("n5 reset isr", 32'(isr5), 32'h0);
        check("n5 reset vidx", 32'(vidx5), 32'h0);
        reset5 = 0; set_prio5 = 1; eoi_idx5 = 3'd3; tick();
        check("n5 set_prio", 32'(low5), 32'd3);
        set_prio5 = 0; irr5 = 5'h11; tick();
        check("n5 int_req", 32'(int_req5), 32'd1);
        inta5 = 1; tick();
        check("n5 ack1 isr", 32'(isr5), 32'h10);
        check("n5 ack1 irr_clear", 32'(clr5), 32'h10);
        check("n5 ack1 int_req low", 32'(int_req5), 32'd0);
        tick();
        check("n5 ack2 vv", 32'(vv5), 32'd1);
        check("n5 ack2 vidx", 32'(vidx5), 32'd4);
        tick();
        check("n5 reack vv", 32'(vv5), 32'd0);
        check("n5 reack clr", 32'(clr5), 32'h10);
        inta5 = 0; reset5 = 1; tick();
        check("n5 midreset vv", 32'(vv5), 32'd0);
        check("n5 midreset isr", 32'(isr5), 32'h0);
        check("n5 midreset lowest", 32'(low5), 32'd4);
        reset5 = 0; inta5 = 1; tick();
        check("n5 post isr", 32'(isr5), 32'h01);
        check("n5 post vv", 32'(vv5), 32'd0);
        tick();
        check("n5 post vv2", 32'(vv5), 32'd1);
        check("n5 post vidx", 32'(vidx5), 32'd0);
        inta5 = 0;
        $display("[TB] n5 sequence done: isr=%02h low=%0d", isr5, low5);

        // ---------------- randomized vs model ----------------
        for (int c = 0; c < 600; c++) begin
            reset       = (c == 0) || ($urandom_range(0, 99) == 0);
            irr         = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
            imr         = 8'($urandom) & 8'($urandom);
            inta        = ($urandom_range(0, 2) == 0);
            aeoi_mode   = 1'($urandom_range(0, 1));
            rotate_aeoi = 1'($urandom_range(0, 1));
            eoi_ns      = ($urandom_range(0, 5) == 0);
            eoi_sp      = ($urandom_range(0, 5) == 0);
            eoi_rotate  = 1'($urandom_range(0, 1));
            set_prio    = ($urandom_range(0, 9) == 0);
            eoi_idx     = 3'($urandom);
            model_step();
            tick();
            check($sformatf("rnd%0d int_req", c), 32'(int_req), 32'(m_int));
            check($sformatf("rnd%0d isr", c), 32'(isr), 32'(m_isr));
            check($sformatf("rnd%0d irr_clear", c), 32'(irr_clear), 32'(m_clr));
            check($sformatf("rnd%0d vector_valid", c), 32'(vector_valid), 32'(m_vv));
            check($sformatf("rnd%0d vector_idx", c), 32'(vector_idx), 32'(m_vidx));
            check($sformatf("rnd%0d lowest_prio", c), 32'(lowest_prio), 32'(m_low));
            $display("[TB] rnd %0d irr=%02h imr=%02h inta=%0b -> isr=%02h vv=%0b vidx=%0d low=%0d",
                     c, irr, imr, inta, isr, vector_valid, vector_idx, lowest_prio);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
